pc_sequencer: RTL and testbench

- Parametrised successor to the 16-bit program counter: sequential increment, absolute jump, PC-relative branch, stall, and call/return through a hardware return-address stack (RAS).
- Sits at the head of the RISCBlade fetch stage and drives the instruction-memory address.
- Control decode supplies one-cycle enable pulses.
- Stack misuse is reported through sticky error flags; it does not corrupt the PC.

---
 rtl/pc_sequencer.sv | 122 ++++++++++++
 tb/tb_pc_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential step, jump, PC-relative branch, stall,
// and call/return through a circular hardware return-address stack.
module pc_sequencer #(
    parameter int               WIDTH     = 16,
    parameter int               STEP      = 2,
    parameter int               RAS_DEPTH = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        jump_en,
    input  logic [WIDTH-1:0]            jump_addr,
    input  logic                        branch_en,
    input  logic [WIDTH-1:0]            branch_off,
    input  logic                        call_en,
    input  logic                        ret_en,
    output logic [WIDTH-1:0]            pc,
    output logic [$clog2(RAS_DEPTH):0]  ras_count,
    output logic                        ras_overflow,
    output logic                        ras_underflow
);

    localparam int               PTR_W  = $clog2(RAS_DEPTH);
    localparam int               CNT_W  = PTR_W + 1;
    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_RET,
        ACT_CALL,
        ACT_JUMP,
        ACT_BRANCH,
        ACT_SEQ
    } action_t;

    // Two's-complement offsets and the sequential step share one modulo-2^WIDTH adder form.
    function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        return a + b;
    endfunction

    action_t                action;
    logic [WIDTH-1:0]       stack [RAS_DEPTH];
    logic [PTR_W-1:0]       sp;
    logic [PTR_W-1:0]       top;
    logic [PTR_W-1:0]       sp_next;
    logic [CNT_W-1:0]       count_next;
    logic [WIDTH-1:0]       pc_next;
    logic [WIDTH-1:0]       link;
    logic                   push;
    logic                   ovf_set;
    logic                   unf_set;

    // sp is the next free slot; the most recent entry sits one below it.
    assign top  = sp - PTR_W'(1);
    assign link = wrap_add(pc, STEP_V);

    always_comb begin
        action = ACT_SEQ;
        if (stall)          action = ACT_HOLD;
        else if (ret_en)    action = ACT_RET;
        else if (call_en)   action = ACT_CALL;
        else if (jump_en)   action = ACT_JUMP;
        else if (branch_en) action = ACT_BRANCH;
    end

    always_comb begin
        pc_next    = link;
        sp_next    = sp;
        count_next = ras_count;
        push       = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        case (action)
            ACT_HOLD: pc_next = pc;
            ACT_RET: begin
                if (ras_count != '0) begin
                    pc_next    = stack[top];
                    sp_next    = top;
                    count_next = ras_count - CNT_W'(1);
                end else begin
                    unf_set = 1'b1;
                end
            end
            ACT_CALL: begin
                // When full, sp already points at the oldest entry, so the push overwrites it.
                push    = 1'b1;
                pc_next = jump_addr;
                sp_next = sp + PTR_W'(1);
                if (ras_count == FULL) ovf_set = 1'b1;
                else                   count_next = ras_count + CNT_W'(1);
            end
            ACT_JUMP:   pc_next = jump_addr;
            ACT_BRANCH: pc_next = wrap_add(pc, branch_off);
            default:    pc_next = link;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc            <= RESET_VEC;
            sp            <= '0;
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc        <= pc_next;
            sp        <= sp_next;
            ras_count <= count_next;
            if (ovf_set) ras_overflow  <= 1'b1;
            if (unf_set) ras_underflow <= 1'b1;
        end
    end

    // Stack storage carries data only; its contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (push && !reset) stack[sp] <= link;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: table vectors plus nested call/return sequences,
// with expected outputs queued at drive time and compared one cycle later.
module tb_pc_sequencer;

    localparam logic [5:0] C_IDLE = 6'b000000;
    localparam logic [5:0] C_RST  = 6'b100000;
    localparam logic [5:0] C_STL  = 6'b010000;
    localparam logic [5:0] C_RET  = 6'b001000;
    localparam logic [5:0] C_CALL = 6'b000100;
    localparam logic [5:0] C_JMP  = 6'b000010;
    localparam logic [5:0] C_BR   = 6'b000001;

    typedef struct {
        logic [5:0]  ctl;
        logic [15:0] addr;
        logic [15:0] off;
        logic [15:0] exp_pc;
        logic [3:0]  exp_cnt;
        logic        exp_ovf;
        logic        exp_unf;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic [3:0]  cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset, stall, jump_en, branch_en, call_en, ret_en;
    logic [15:0] jump_addr, branch_off;
    logic [15:0] pc;
    logic [3:0]  ras_count;
    logic        ras_overflow, ras_underflow;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];
    exp_t sb[$];

    pc_sequencer #(
        .WIDTH     (16),
        .STEP      (2),
        .RAS_DEPTH (8),
        .RESET_VEC (16'h0000)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .jump_en       (jump_en),
        .jump_addr     (jump_addr),
        .branch_en     (branch_en),
        .branch_off    (branch_off),
        .call_en       (call_en),
        .ret_en        (ret_en),
        .pc            (pc),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input string name, input logic [5:0] ctl, input logic [15:0] addr,
                        input logic [15:0] off, input logic [15:0] epc, input logic [3:0] ecnt,
                        input logic eovf, input logic eunf);
        exp_t e;
        @(negedge clock);
        {reset, stall, ret_en, call_en, jump_en, branch_en} = ctl;
        jump_addr  = addr;
        branch_off = off;
        e.pc  = epc;
        e.cnt = ecnt;
        e.ovf = eovf;
        e.unf = eunf;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check({name, " scoreboard"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({name, " pc"},  32'(pc),            32'(e.pc));
            check({name, " cnt"}, 32'(ras_count),     32'(e.cnt));
            check({name, " ovf"}, 32'(ras_overflow),  32'(e.ovf));
            check({name, " unf"}, 32'(ras_underflow), 32'(e.unf));
        end
    endtask

    function automatic void add(input logic [5:0] c, input logic [15:0] a, input logic [15:0] o,
                                input logic [15:0] ep, input logic [3:0] ec,
                                input logic eo, input logic eu);
        vec_t v;
        v.ctl = c; v.addr = a; v.off = o;
        v.exp_pc = ep; v.exp_cnt = ec; v.exp_ovf = eo; v.exp_unf = eu;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [15:0] epc;
        logic [3:0]  ecnt;
        {reset, stall, ret_en, call_en, jump_en, branch_en} = C_RST;
        jump_addr  = '0;
        branch_off = '0;

        // Reset, free-run, reset mid-count
        add(C_RST,  16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
        add(C_IDLE, 16'h0000, 16'h0000, 16'h0002, 4'd0, 1'b0, 1'b0);
        add(C_IDLE, 16'h0000, 16'h0000, 16'h0004, 4'd0, 1'b0, 1'b0);
        add(C_IDLE, 16'h0000, 16'h0000, 16'h0006, 4'd0, 1'b0, 1'b0);
        add(C_IDLE, 16'h0000, 16'h0000, 16'h0008, 4'd0, 1'b0, 1'b0);
        add(C_IDLE, 16'h0000, 16'h0000, 16'h000A, 4'd0, 1'b0, 1'b0);
        add(C_RST | C_JMP, 16'h1234, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
        // Negative branch and wrap-around
        add(C_JMP,  16'h0010, 16'h0000, 16'h0010, 4'd0, 1'b0, 1'b0);
        add(C_BR,   16'h0000, 16'hFFF8, 16'h0008, 4'd0, 1'b0, 1'b0);
        add(C_JMP,  16'hFFFE, 16'h0000, 16'hFFFE, 4'd0, 1'b0, 1'b0);
        add(C_IDLE, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
        // Call, two sequential steps, return
        add(C_JMP,  16'h0020, 16'h0000, 16'h0020, 4'd0, 1'b0, 1'b0);
        add(C_CALL, 16'h0100, 16'h0000, 16'h0100, 4'd1, 1'b0, 1'b0);
        add(C_IDLE, 16'h0000, 16'h0000, 16'h0102, 4'd1, 1'b0, 1'b0);
        add(C_IDLE, 16'h0000, 16'h0000, 16'h0104, 4'd1, 1'b0, 1'b0);
        add(C_RET,  16'h0000, 16'h0000, 16'h0022, 4'd0, 1'b0, 1'b0);
        // Priority: ret over call/jump, jump over branch
        add(C_CALL, 16'h0200, 16'h0000, 16'h0200, 4'd1, 1'b0, 1'b0);
        add(C_RET | C_CALL | C_JMP, 16'h0300, 16'h0000, 16'h0024, 4'd0, 1'b0, 1'b0);
        add(C_JMP | C_BR, 16'h0400, 16'h0010, 16'h0400, 4'd0, 1'b0, 1'b0);
        // Stall with call pending, then release
        add(C_STL | C_CALL, 16'h0500, 16'h0000, 16'h0400, 4'd0, 1'b0, 1'b0);
        add(C_STL | C_CALL, 16'h0500, 16'h0000, 16'h0400, 4'd0, 1'b0, 1'b0);
        add(C_STL | C_CALL, 16'h0500, 16'h0000, 16'h0400, 4'd0, 1'b0, 1'b0);
        add(C_CALL, 16'h0500, 16'h0000, 16'h0500, 4'd1, 1'b0, 1'b0);
        add(C_IDLE, 16'h0000, 16'h0000, 16'h0502, 4'd1, 1'b0, 1'b0);
        add(C_RET,  16'h0000, 16'h0000, 16'h0402, 4'd0, 1'b0, 1'b0);
        add(C_STL | C_RET, 16'h0000, 16'h0000, 16'h0402, 4'd0, 1'b0, 1'b0);
        add(C_RST | C_STL, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].ctl, tbl[i].addr, tbl[i].off,
                 tbl[i].exp_pc, tbl[i].exp_cnt, tbl[i].exp_ovf, tbl[i].exp_unf);
        end

        // Nine nested calls into an eight-deep stack
        step("nest_rst", C_RST, 16'h0, 16'h0, 16'h0000, 4'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            epc  = 16'(i * 16);
            ecnt = (i - 1 > 8) ? 4'd8 : 4'(i - 1);
            step($sformatf("nest_jump%0d", i), C_JMP, epc, 16'h0, epc, ecnt, 1'b0, 1'b0);
            epc  = 16'h1000 + 16'(i * 256);
            ecnt = (i > 8) ? 4'd8 : 4'(i);
            step($sformatf("nest_call%0d", i), C_CALL, epc, 16'h0, epc, ecnt, i == 9, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            epc = 16'h0092 - 16'(k * 16);
            step($sformatf("nest_ret%0d", k), C_RET, 16'h0, 16'h0, epc, 4'(7 - k), 1'b1, 1'b0);
        end
        step("under_ret",   C_RET,  16'h0, 16'h0, 16'h0024, 4'd0, 1'b1, 1'b1);
        step("sticky_idle", C_IDLE, 16'h0, 16'h0, 16'h0026, 4'd0, 1'b1, 1'b1);
        step("flag_clear",  C_RST,  16'h0, 16'h0, 16'h0000, 4'd0, 1'b0, 1'b0);

        @(negedge clock);
        {reset, stall, ret_en, call_en, jump_en, branch_en} = C_IDLE;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
